uart_rx_param: RTL

Parametrised asynchronous serial receiver for the CoreUARTapb family. It replaces the fixed 8-bit receiver with a configurable-width, configurable-oversampling block. Adds runtime character length, 1/2 stop-bit checking, 3-sample majority voting, false-start rejection and optional line-break detection. It sits between the RX pad synchroniser and the APB register/FIFO layer and delivers one character at a time through a valid/ready holding register.

---
 rtl/uart_rx_param.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with 3-sample majority voting, runtime framing and a valid/ready holding register.
// Define UART_RX_BREAK_DETECT_EN to add line-break detection (BREAK state and break_det pulse).
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  baud_en,
    input  logic                  rx,
    input  logic [3:0]            char_len,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  stop2,
    input  logic                  rx_ready,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  break_det,
    output logic                  rx_idle
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [2:0] BREAK = 3'd5;
`endif
    logic [2:0] state, state_n, samp;
    logic [CW-1:0] cnt;
    logic [3:0] len, len_eff, bcnt;
    logic [DATA_WIDTH-1:0] sh;
    logic maj, mid, full, pe, po, s2, pb, ferr, stopn, brk, fin, ovf;
    assign maj = (samp[2] & samp[1]) | (samp[2] & samp[0]) | (samp[1] & samp[0]);
    assign mid = baud_en && cnt == CW'(OVERSAMPLE / 2 - 1);
    assign full = baud_en && cnt == CW'(OVERSAMPLE - 1);
    assign len_eff = char_len < 4'd5 ? 4'd5 : char_len > 4'(DATA_WIDTH) ? 4'(DATA_WIDTH) : char_len;
`ifdef UART_RX_BREAK_DETECT_EN
    // Data bits live in sh (cleared at start) and the parity bit in pb, so all-zero is a simple compare.
    assign brk = state == STOP && full && !stopn && sh == '0 && !pb && !maj;
`else
    assign brk = 1'b0;
`endif
    assign fin = state == STOP && full && (stopn || !s2) && !brk;
    assign ovf = fin && rx_valid && !rx_ready;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = baud_en && !maj ? START : IDLE;
            START:   state_n = mid ? (maj ? IDLE : DATA) : START;
            DATA:    state_n = full && bcnt == len - 4'd1 ? (pe ? PARITY : STOP) : DATA;
            PARITY:  state_n = full ? STOP : PARITY;
            STOP:    state_n = fin ? IDLE : STOP;
`ifdef UART_RX_BREAK_DETECT_EN
            BREAK:   state_n = baud_en && maj ? IDLE : BREAK;
`endif
            default: state_n = IDLE;
        endcase
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk) state_n = BREAK;
`endif
    end
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state <= IDLE;
            samp <= 3'b111;
            cnt <= '0;
            len <= 4'd5;
            bcnt <= '0;
            sh <= '0;
            {pe, po, s2, pb, ferr, stopn} <= '0;
            rx_data <= '0;
            {rx_valid, parity_err, frame_err, overrun, break_det} <= '0;
            rx_idle <= 1'b1;
        end else begin
            state <= state_n;
            rx_idle <= state_n == IDLE;
            break_det <= brk;
            overrun <= ovf || (overrun && !err_clr);
            if (baud_en) begin
                samp <= {samp[1:0], rx};
                cnt <= state_n != state || full ? '0 : cnt + 1'b1;
            end
            // Framing options are frozen once the start bit is confirmed.
            if (state == START && mid && !maj) begin
                len <= len_eff;
                pe <= par_en;
                po <= par_odd;
                s2 <= stop2;
                sh <= '0;
                bcnt <= '0;
                {pb, ferr, stopn} <= '0;
            end
            if (state == DATA && full) begin
                sh <= {maj, sh[DATA_WIDTH-1:1]};
                bcnt <= bcnt + 4'd1;
            end
            if (state == PARITY && full) pb <= maj;
            if (state == STOP && full) begin
                stopn <= 1'b1;
                ferr <= ferr || !maj;
            end
            if (fin && !ovf) begin
                rx_data <= sh >> (4'(DATA_WIDTH) - len);
                parity_err <= pe && ((^sh ^ pb) != po);
                frame_err <= ferr || !maj;
                rx_valid <= 1'b1;
            end else if (!fin && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
endmodule
